// File: rtl/px_word_packer_if.sv
// Pixel-to-word packer bus: sequencer/FIFO-side signals grouped in one bundle.
// The master side is the capture environment (sequencer + FIFO status); the
// slave side is the packer itself.
interface px_word_packer_if #(
    parameter int PX_WIDTH   = 8,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  frame_start;
    logic                  frame_end;
    logic [PX_WIDTH-1:0]   px_in;
    logic                  px_valid;
    logic                  fifo_full;
    logic [WORD_WIDTH-1:0] fifo_data;
    logic                  fifo_we;
    logic [CNT_WIDTH-1:0]  word_count;
    logic                  dropped;
    logic                  frame_done;
    logic                  active;

    modport master (
        output frame_start, frame_end, px_in, px_valid, fifo_full,
        input  fifo_data, fifo_we, word_count, dropped, frame_done, active
    );

    modport slave (
        input  frame_start, frame_end, px_in, px_valid, fifo_full,
        output fifo_data, fifo_we, word_count, dropped, frame_done, active
    );
endinterface

// File: rtl/px_word_packer.sv
// Packs consecutive PX_WIDTH pixel samples into WORD_WIDTH FIFO words
// (first pixel in the least significant lane), handles frame start/end
// framing, pads and flushes the partial last word, and reports per-frame
// word count and sticky drop status.
module px_word_packer #(
    parameter int                  PX_WIDTH   = 8,
    parameter int                  WORD_WIDTH = 32,
    parameter logic [PX_WIDTH-1:0] PAD_VALUE  = 8'h00,
    parameter int                  CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              reset,
    px_word_packer_if.slave  bus
);
    localparam int LANES  = WORD_WIDTH / PX_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LANE_W-1:0]     r_lane;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] r_fifo_data;
    logic                  r_fifo_we;
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic                  r_dropped;
    logic                  r_frame_done;
    logic                  r_active;

    logic [WORD_WIDTH-1:0] w_merged;
    logic                  w_issue_req;
    logic [WORD_WIDTH-1:0] w_issue_word;

    // Place one pixel into the given lane of a word, leaving other lanes intact.
    function automatic logic [WORD_WIDTH-1:0] f_insert(
        input logic [WORD_WIDTH-1:0] word,
        input logic [LANE_W-1:0]     lane,
        input logic [PX_WIDTH-1:0]   px
    );
        logic [WORD_WIDTH-1:0] v;
        v = word;
        for (int k = 0; k < LANES; k++) begin
            if (LANE_W'(k) == lane) begin
                v[k*PX_WIDTH +: PX_WIDTH] = px;
            end else begin
                v[k*PX_WIDTH +: PX_WIDTH] = word[k*PX_WIDTH +: PX_WIDTH];
            end
        end
        return v;
    endfunction

    // Fill every lane from first_pad upward with the pad pixel.
    function automatic logic [WORD_WIDTH-1:0] f_pad(
        input logic [WORD_WIDTH-1:0] word,
        input logic [LANE_W-1:0]     first_pad
    );
        logic [WORD_WIDTH-1:0] v;
        v = word;
        for (int k = 0; k < LANES; k++) begin
            if (k >= int'(first_pad)) begin
                v[k*PX_WIDTH +: PX_WIDTH] = PAD_VALUE;
            end else begin
                v[k*PX_WIDTH +: PX_WIDTH] = word[k*PX_WIDTH +: PX_WIDTH];
            end
        end
        return v;
    endfunction

    // Decide whether a finished word is presented for issue at this edge, and which.
    // frame_start has priority: a restart discards whatever was being assembled.
    always_comb begin
        w_merged     = f_insert(r_shift, r_lane, bus.px_in);
        w_issue_req  = 1'b0;
        w_issue_word = w_merged;
        case (r_state)
            S_ACTIVE: begin
                if (!bus.frame_start && bus.px_valid && (r_lane == LAST_LANE)) begin
                    w_issue_req = 1'b1;
                end else begin
                    w_issue_req = 1'b0;
                end
            end
            S_FLUSH: begin
                if (!bus.frame_start && (r_lane != {LANE_W{1'b0}})) begin
                    w_issue_req  = 1'b1;
                    w_issue_word = f_pad(r_shift, r_lane);
                end else begin
                    w_issue_req = 1'b0;
                end
            end
            default: begin
                w_issue_req = 1'b0;
            end
        endcase
    end

    // Framing FSM, lane assembly and registered FIFO-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_lane       <= {LANE_W{1'b0}};
            r_shift      <= {WORD_WIDTH{1'b0}};
            r_fifo_data  <= {WORD_WIDTH{1'b0}};
            r_fifo_we    <= 1'b0;
            r_word_count <= {CNT_WIDTH{1'b0}};
            r_dropped    <= 1'b0;
            r_frame_done <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_fifo_we    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_state      <= S_ACTIVE;
                        r_lane       <= {LANE_W{1'b0}};
                        r_shift      <= {WORD_WIDTH{1'b0}};
                        r_word_count <= {CNT_WIDTH{1'b0}};
                        r_dropped    <= 1'b0;
                        r_active     <= 1'b1;
                    end else begin
                        r_active     <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    r_active <= 1'b1;
                    if (bus.frame_start) begin
                        r_lane       <= {LANE_W{1'b0}};
                        r_shift      <= {WORD_WIDTH{1'b0}};
                        r_word_count <= {CNT_WIDTH{1'b0}};
                        r_dropped    <= 1'b0;
                    end else begin
                        if (bus.px_valid) begin
                            r_shift <= w_merged;
                            if (r_lane == LAST_LANE) begin
                                r_lane <= {LANE_W{1'b0}};
                            end else begin
                                r_lane <= r_lane + LANE_W'(1);
                            end
                        end else begin
                            r_lane <= r_lane;
                        end
                        if (bus.frame_end) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_state <= S_ACTIVE;
                        end
                    end
                end
                S_FLUSH: begin
                    r_lane <= {LANE_W{1'b0}};
                    if (bus.frame_start) begin
                        r_state      <= S_ACTIVE;
                        r_shift      <= {WORD_WIDTH{1'b0}};
                        r_word_count <= {CNT_WIDTH{1'b0}};
                        r_dropped    <= 1'b0;
                        r_active     <= 1'b1;
                    end else begin
                        r_state      <= S_IDLE;
                        r_active     <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_lane   <= {LANE_W{1'b0}};
                    r_active <= 1'b0;
                end
            endcase

            // Word issue: a full FIFO discards the word and latches the drop flag.
            if (w_issue_req) begin
                if (bus.fifo_full) begin
                    r_dropped <= 1'b1;
                end else begin
                    r_fifo_we   <= 1'b1;
                    r_fifo_data <= w_issue_word;
                    if (r_word_count != CNT_MAX) begin
                        r_word_count <= r_word_count + CNT_WIDTH'(1);
                    end else begin
                        r_word_count <= r_word_count;
                    end
                end
            end
        end
    end

    assign bus.fifo_data  = r_fifo_data;
    assign bus.fifo_we    = r_fifo_we;
    assign bus.word_count = r_word_count;
    assign bus.dropped    = r_dropped;
    assign bus.frame_done = r_frame_done;
    assign bus.active     = r_active;
endmodule

// File: tb/tb_px_word_packer.sv
// Self-checking bench for px_word_packer: directed vector table, hand-written
// restart/reset sequences, then randomized traffic against a queue-based model.
module tb_px_word_packer;
    logic clk;
    logic reset;

    px_word_packer_if #(.PX_WIDTH(8), .WORD_WIDTH(32), .CNT_WIDTH(16)) bus ();

    px_word_packer #(
        .PX_WIDTH(8), .WORD_WIDTH(32), .PAD_VALUE(8'h00), .CNT_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fs, fe, pv;
        logic [7:0]  px;
        logic        full;
        logic        we;
        logic [31:0] data;
        logic [15:0] wc;
        logic        drop, done, act;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fs, input logic fe, input logic pv, input logic [7:0] px,
                       input logic full, input logic we, input logic [31:0] data,
                       input logic [15:0] wc, input logic drop, input logic done, input logic act);
        vec_t v;
        v.fs = fs; v.fe = fe; v.pv = pv; v.px = px; v.full = full;
        v.we = we; v.data = data; v.wc = wc; v.drop = drop; v.done = done; v.act = act;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic we, input logic [31:0] data,
                             input logic [15:0] wc, input logic drop, input logic done,
                             input logic act);
        chk($sformatf("%s.fifo_we", tag),    32'(bus.fifo_we),    32'(we));
        chk($sformatf("%s.fifo_data", tag),  bus.fifo_data,       data);
        chk($sformatf("%s.word_count", tag), 32'(bus.word_count), 32'(wc));
        chk($sformatf("%s.dropped", tag),    32'(bus.dropped),    32'(drop));
        chk($sformatf("%s.frame_done", tag), 32'(bus.frame_done), 32'(done));
        chk($sformatf("%s.active", tag),     32'(bus.active),     32'(act));
    endtask

    // Apply inputs for one clock, then sample just after the active edge.
    task automatic step(input logic fs, input logic fe, input logic pv,
                        input logic [7:0] px, input logic full);
        bus.frame_start = fs;
        bus.frame_end   = fe;
        bus.px_valid    = pv;
        bus.px_in       = px;
        bus.fifo_full   = full;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a frame is a stream of pixels; every four collected
    // pixels form a word (first pixel lowest byte); frame end pads the rest.
    int          m_q[$];
    bit          m_in_frame, m_flushing;
    logic [31:0] m_data;
    int          m_wc;
    bit          m_drop, m_we, m_done;

    function automatic logic [31:0] pack_queue();
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < m_q.size(); i++) w = w | (32'(m_q[i]) << (8 * i));
        return w;
    endfunction

    task automatic model_emit(input logic [31:0] w, input bit full);
        if (full) begin
            m_drop = 1'b1;
        end else begin
            m_we   = 1'b1;
            m_data = w;
            if (m_wc < 65535) m_wc++;
        end
    endtask

    task automatic model_step(input bit fs, input bit fe, input bit pv,
                              input logic [7:0] px, input bit full);
        m_we   = 1'b0;
        m_done = 1'b0;
        if (fs) begin
            m_q.delete();
            m_wc = 0; m_drop = 1'b0;
            m_in_frame = 1'b1; m_flushing = 1'b0;
        end else if (m_flushing) begin
            if (m_q.size() > 0) model_emit(pack_queue(), full);
            m_q.delete();
            m_flushing = 1'b0;
            m_done = 1'b1;
        end else if (m_in_frame) begin
            if (pv) begin
                m_q.push_back(int'(px));
                if (m_q.size() == 4) begin
                    model_emit(pack_queue(), full);
                    m_q.delete();
                end
            end
            if (fe) begin
                m_in_frame = 1'b0;
                m_flushing = 1'b1;
            end
        end
    endtask

    localparam logic [31:0] D1 = 32'h44332211;
    localparam logic [31:0] D2 = 32'h00006655;

    initial begin
        reset = 1'b0;
        bus.frame_start = 1'b0; bus.frame_end = 1'b0; bus.px_valid = 1'b0;
        bus.px_in = 8'h00; bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // fs fe pv px full | we data wc drop done act
        add(1,0,0,8'h00,0, 0,32'h0,0,0,0,1);
        add(0,0,1,8'h11,0, 0,32'h0,0,0,0,1);
        add(0,0,1,8'h22,0, 0,32'h0,0,0,0,1);
        add(0,0,1,8'h33,0, 0,32'h0,0,0,0,1);
        add(0,0,1,8'h44,0, 1,D1,1,0,0,1);
        add(0,0,1,8'h55,0, 0,D1,1,0,0,1);
        add(0,1,1,8'h66,0, 0,D1,1,0,0,1);
        add(0,0,0,8'h00,0, 1,D2,2,0,1,0);
        add(0,0,1,8'h77,0, 0,D2,2,0,0,0);
        add(0,1,1,8'h78,0, 0,D2,2,0,0,0);
        add(1,0,0,8'h00,0, 0,D2,0,0,0,1);
        add(0,0,1,8'h11,0, 0,D2,0,0,0,1);
        add(0,0,1,8'h22,0, 0,D2,0,0,0,1);
        add(0,0,1,8'h33,0, 0,D2,0,0,0,1);
        add(0,1,1,8'h44,0, 1,D1,1,0,0,1);
        add(0,0,1,8'h99,0, 0,D1,1,0,1,0);
        add(0,0,0,8'h00,0, 0,D1,1,0,0,0);
        add(1,0,0,8'h00,0, 0,D1,0,0,0,1);
        add(0,0,1,8'h11,0, 0,D1,0,0,0,1);
        add(0,0,1,8'h22,0, 0,D1,0,0,0,1);
        add(0,0,1,8'h33,0, 0,D1,0,0,0,1);
        add(0,0,1,8'h44,0, 1,D1,1,0,0,1);
        add(0,0,1,8'h55,0, 0,D1,1,0,0,1);
        add(0,0,1,8'h66,0, 0,D1,1,0,0,1);
        add(0,0,1,8'h77,0, 0,D1,1,0,0,1);
        add(0,0,1,8'h88,1, 0,D1,1,1,0,1);
        add(0,1,0,8'h00,0, 0,D1,1,1,0,1);
        add(0,0,0,8'h00,0, 0,D1,1,1,1,0);
        add(0,0,0,8'h00,0, 0,D1,1,1,0,0);
        add(1,0,0,8'h00,0, 0,D1,0,0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].fs, tbl[i].fe, tbl[i].pv, tbl[i].px, tbl[i].full);
            check_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].data, tbl[i].wc,
                      tbl[i].drop, tbl[i].done, tbl[i].act);
        end

        // Restart mid-word: the partial 11/22/33 word must vanish.
        step(0,0,1,8'h11,0); step(0,0,1,8'h22,0); step(0,0,1,8'h33,0);
        chk("restart.pre_we", 32'(bus.fifo_we), 32'h0);
        step(1,0,0,8'h00,0);
        check_all("restart.fs", 1'b0, D1, 16'd0, 1'b0, 1'b0, 1'b1);
        step(0,0,1,8'hA1,0); step(0,0,1,8'hA2,0); step(0,0,1,8'hA3,0);
        chk("restart.mid_we", 32'(bus.fifo_we), 32'h0);
        step(0,0,1,8'hA4,0);
        check_all("restart.word", 1'b1, 32'hA4A3A2A1, 16'd1, 1'b0, 1'b0, 1'b1);
        step(0,1,0,8'h00,0);
        chk("restart.flush_we", 32'(bus.fifo_we), 32'h0);
        step(0,0,0,8'h00,0);
        check_all("restart.done", 1'b0, 32'hA4A3A2A1, 16'd1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-frame, then pixels without frame_start.
        step(1,0,0,8'h00,0); step(0,0,1,8'h11,0); step(0,0,1,8'h22,0);
        chk("rstmid.active_before", 32'(bus.active), 32'h1);
        reset = 1'b0;
        #1;
        check_all("rstmid.async", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, (i < 4) ? 1'b1 : 1'b0, 8'hA1 + 8'(i), 1'b0);
            chk($sformatf("rstmid.nowrite%0d", i), 32'(bus.fifo_we), 32'h0);
            chk($sformatf("rstmid.idle%0d", i), 32'(bus.active), 32'h0);
        end

        // Randomized traffic against the model (DUT is idle with cleared outputs).
        m_q.delete();
        m_in_frame = 1'b0; m_flushing = 1'b0;
        m_data = 32'h0; m_wc = 0; m_drop = 1'b0; m_we = 1'b0; m_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit fs, fe, pv, full;
            logic [7:0] px;
            fs   = ($urandom_range(0, 99) < 3);
            fe   = ($urandom_range(0, 99) < 4);
            pv   = ($urandom_range(0, 99) < 75);
            full = ($urandom_range(0, 99) < 20);
            px   = 8'($urandom);
            model_step(fs, fe, pv, px, full);
            step(fs, fe, pv, px, full);
            check_all($sformatf("rnd%0d", c), m_we, m_data, 16'(m_wc), m_drop, m_done,
                      m_in_frame | m_flushing);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
